rdy_int_scheduler: RTL and testbench

Sits between the sensor front-ends (MPU accel/gyro, MAG, optical flow, baro, ultrasonic) and the FSMC register block. Captures each source's data-ready rising edge as a pending bit and grants one source at a time using round-robin arbitration. For each grant it drives the host interrupt line and waits for a host acknowledge. Enforces an ack timeout and a minimum hold-off between interrupts, so the STM32 gets exactly one well-paced interrupt per sensor update.

---
 rtl/rdy_int_scheduler.sv | 138 +++++++++++++
 tb/tb_rdy_int_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rdy_int_scheduler.sv
// Round-robin scheduler turning sensor data-ready edges into one paced, acknowledged host interrupt at a time.
// Optional overrun counter is enabled by defining RDY_OVR_CNT_EN; without it Ovr_Cnt is tied to 0.
module rdy_int_scheduler #(
  parameter int N_SRC       = 5,
  parameter int HOLDOFF_CYC = 16,
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             Clr_Rdy_flg,
  input  logic             En,
  input  logic [N_SRC-1:0] Rdy_In,
  input  logic [N_SRC-1:0] Mask,
  input  logic             Ack,
  output logic             INT_n,
  output logic [2:0]       Grant_Id,
  output logic [N_SRC-1:0] Pending,
  output logic             Timeout_Flg,
  output logic [7:0]       Ovr_Cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, HOLDOFF} state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF_CYC > 0) ? CNT_W'(HOLDOFF_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N_SRC-1:0]   rdy_d, rise, cand, clr_vec, set_vec, pend_nxt;
  logic [2:0]         rr_ptr, rr_nxt, winner, gid_nxt, idx;
  logic [3:0]         sum;
  logic               any_cand, int_n_nxt, tflg_nxt;

  assign rise     = Rdy_In & ~rdy_d;
  assign cand     = Pending & Mask;
  assign any_cand = |cand;

  // Walk the search order backwards so the last hit is the first eligible source from rr_ptr.
  always_comb begin
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + 4'(k);
      if (sum >= 4'(N_SRC)) sum = sum - 4'(N_SRC);
      idx = sum[2:0];
      if (cand[idx]) winner = idx;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rr_nxt    = rr_ptr;
    gid_nxt   = Grant_Id;
    int_n_nxt = 1'b1;
    tflg_nxt  = 1'b0;
    clr_vec   = '0;
    set_vec   = '0;
    case (state)
      IDLE: begin
        if (En && any_cand) begin
          state_nxt = WAIT_ACK;
          gid_nxt   = winner;
          clr_vec   = N_SRC'(1) << winner;
          cnt_nxt   = '0;
          int_n_nxt = 1'b0;
          rr_nxt    = (winner == 3'(N_SRC - 1)) ? 3'd0 : winner + 3'd1;
        end
      end
      WAIT_ACK: begin
        int_n_nxt = 1'b0;
        if (Ack) begin
          state_nxt = HOLDOFF;
          cnt_nxt   = HOLD_LOAD;
          int_n_nxt = 1'b1;
        end else if (cnt == TO_LAST) begin
          state_nxt = HOLDOFF;
          cnt_nxt   = HOLD_LOAD;
          int_n_nxt = 1'b1;
          tflg_nxt  = 1'b1;
          set_vec   = N_SRC'(1) << Grant_Id;
        end else if (!En) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          int_n_nxt = 1'b1;
          set_vec   = N_SRC'(1) << Grant_Id;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
    // A fresh edge always lands in Pending, even if the same bit is being granted now.
    pend_nxt = (Pending & ~clr_vec) | set_vec | rise;
  end

  always_ff @(posedge CLK or posedge Clr_Rdy_flg) begin
    if (Clr_Rdy_flg) begin
      state       <= IDLE;
      cnt         <= '0;
      rr_ptr      <= '0;
      rdy_d       <= '0;
      Pending     <= '0;
      Grant_Id    <= '0;
      INT_n       <= 1'b1;
      Timeout_Flg <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rr_ptr      <= rr_nxt;
      rdy_d       <= Rdy_In;
      Pending     <= pend_nxt;
      Grant_Id    <= gid_nxt;
      INT_n       <= int_n_nxt;
      Timeout_Flg <= tflg_nxt;
    end
  end

`ifdef RDY_OVR_CNT_EN
  logic [N_SRC-1:0] live;
  logic             ovr;
  assign live = (state == WAIT_ACK) ? (N_SRC'(1) << Grant_Id) : '0;
  assign ovr  = |(rise & (Pending | live));

  always_ff @(posedge CLK or posedge Clr_Rdy_flg) begin
    if (Clr_Rdy_flg)                     Ovr_Cnt <= '0;
    else if (ovr && (Ovr_Cnt != 8'hFF))  Ovr_Cnt <= Ovr_Cnt + 8'd1;
  end
`else
  assign Ovr_Cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rdy_int_scheduler.sv
// Directed plan sequences plus randomized traffic, checked every cycle against a timer-based reference model.
module tb_rdy_int_scheduler;
  localparam int N  = 5;
  localparam int HO = 16;
  localparam int TO = 40;
`ifdef RDY_OVR_CNT_EN
  localparam int OVR_EXP = 2;
`else
  localparam int OVR_EXP = 0;
`endif

  logic         CLK = 1'b0;
  logic         Clr_Rdy_flg, En, Ack;
  logic [N-1:0] Rdy_In, Mask, Pending;
  logic         INT_n, Timeout_Flg;
  logic [2:0]   Grant_Id;
  logic [7:0]   Ovr_Cnt;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  rdy_int_scheduler #(.N_SRC(N), .HOLDOFF_CYC(HO), .TIMEOUT_CYC(TO), .CNT_W(16)) dut (
    .CLK(CLK), .Clr_Rdy_flg(Clr_Rdy_flg), .En(En), .Rdy_In(Rdy_In), .Mask(Mask),
    .Ack(Ack), .INT_n(INT_n), .Grant_Id(Grant_Id), .Pending(Pending),
    .Timeout_Flg(Timeout_Flg), .Ovr_Cnt(Ovr_Cnt)
  );

  // Reference model: interrupt line as a flag with an age timer and a quiet-period timer.
  bit         m_low, m_to;
  int         m_gid, m_ptr, m_age, m_quiet, m_ovr;
  bit [N-1:0] m_pend, m_prev;

  function automatic bit has(input bit [N-1:0] v, input int j);
    return ((v >> j) & N'(1)) != '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_low = 0; m_to = 0; m_gid = 0; m_ptr = 0; m_age = 0; m_quiet = 0; m_ovr = 0;
    m_pend = '0; m_prev = '0;
  endtask

  task automatic model_step();
    bit [N-1:0] rise, old;
    bit ovr;
    int w, j;
    rise   = N'(Rdy_In) & ~m_prev;
    m_prev = N'(Rdy_In);
    old    = m_pend;
    ovr    = 0;
    for (int i = 0; i < N; i++)
      if (has(rise, i) && (has(old, i) || (m_low && m_gid == i))) ovr = 1;
    m_to = 0;
    if (m_low) begin
      if (Ack) begin
        m_low = 0; m_quiet = (HO > 0) ? HO : 1;
      end else if (m_age == TO - 1) begin
        m_low = 0; m_to = 1; m_pend |= N'(1) << m_gid; m_quiet = (HO > 0) ? HO : 1;
      end else if (!En) begin
        m_low = 0; m_pend |= N'(1) << m_gid; m_quiet = 0;
      end else m_age++;
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else if (En) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (w < 0 && has(m_pend, j) && has(N'(Mask), j)) w = j;
      end
      if (w >= 0) begin
        m_low = 1; m_gid = w; m_pend &= ~(N'(1) << w); m_age = 0; m_ptr = (w + 1) % N;
      end
    end
    m_pend |= rise;
`ifdef RDY_OVR_CNT_EN
    if (ovr && m_ovr < 255) m_ovr++;
`endif
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, "_int_n"}, INT_n, !m_low);
    chk({tag, "_gid"}, Grant_Id, m_gid);
    chk({tag, "_pend"}, Pending, m_pend);
    chk({tag, "_tflg"}, Timeout_Flg, m_to);
    chk({tag, "_ovr"}, Ovr_Cnt, m_ovr);
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    cmp_all("cyc");
  endtask

  task automatic do_reset();
    Clr_Rdy_flg = 1'b1;
    #1;
    model_reset();
    cmp_all("rst");
    #1;
    Clr_Rdy_flg = 1'b0;
  endtask

  task automatic ack_now();
    Ack = 1'b1; cycle(); Ack = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    Rdy_In = v; cycle(); Rdy_In = '0;
  endtask

  task automatic wait_grant(input string tag, output int id, output int gap);
    gap = 0;
    while (INT_n !== 1'b0 && gap < 200) begin cycle(); gap++; end
    chk({tag, "_grant_seen"}, INT_n, 0);
    id = Grant_Id;
  endtask

  initial begin
    int id, gap, tcnt;
    int ord[3];
    Clr_Rdy_flg = 0; En = 0; Ack = 0; Rdy_In = '0; Mask = '0;
    #2 do_reset();

    // 1: two-edge latency, ack release, hold-off spacing
    Mask = '1; En = 1;
    Rdy_In = 5'b00001; cycle();
    chk("t1_pend_set", Pending, 5'b00001);
    chk("t1_int_not_yet", INT_n, 1);
    Rdy_In = '0; cycle();
    chk("t1_int_low", INT_n, 0);
    chk("t1_gid", Grant_Id, 0);
    chk("t1_pend_clr", Pending, 0);
    repeat (3) cycle();
    ack_now();
    chk("t1_release", INT_n, 1);
    pulse(5'b00001);
    for (int k = 0; k < 15; k++) begin cycle(); chk("t1_holdoff", INT_n, 1); end
    cycle();
    chk("t1_regrant", INT_n, 0);
    ack_now();

    // 2: simultaneous rise, round-robin from 0
    do_reset();
    pulse(5'b11111);
    for (int s = 0; s < N; s++) begin
      wait_grant("t2", id, gap);
      chk("t2_order", id, s);
      if (s > 0) chk("t2_gap_ok", gap >= HO, 1);
      ack_now();
    end

    // 3: pointer at 3, pending {0,1,4}
    pulse(5'b00100);
    wait_grant("t3a", id, gap);
    chk("t3_first", id, 2);
    ack_now();
    pulse(5'b10011);
    ord[0] = 4; ord[1] = 0; ord[2] = 1;
    for (int s = 0; s < 3; s++) begin
      wait_grant("t3", id, gap);
      chk("t3_order", id, ord[s]);
      ack_now();
    end

    // 4: ack timeout
    pulse(5'b00100);
    wait_grant("t4", id, gap);
    tcnt = 0;
    for (int k = 0; k < TO + 2; k++) begin cycle(); if (Timeout_Flg === 1'b1) tcnt++; end
    chk("t4_tflg_once", tcnt, 1);
    chk("t4_int_high", INT_n, 1);
    chk("t4_pend2", Pending[2], 1);
    wait_grant("t4r", id, gap);
    chk("t4_regrant_id", id, 2);
    ack_now();

    // 5: masked pending, unmask, En drop
    repeat (20) cycle();
    Mask = 5'h1E;
    pulse(5'b00001);
    for (int k = 0; k < 3; k++) begin cycle(); chk("t5_masked", INT_n, 1); end
    chk("t5_pend_held", Pending, 5'b00001);
    Mask = 5'h1F; cycle();
    chk("t5_unmask_grant", INT_n, 0);
    chk("t5_gid", Grant_Id, 0);
    repeat (2) cycle();
    En = 0; cycle();
    chk("t5_en_abort", INT_n, 1);
    chk("t5_pend_reset", Pending[0], 1);
    for (int k = 0; k < 5; k++) begin cycle(); chk("t5_en_off", INT_n, 1); end
    En = 1; cycle();
    chk("t5_en_back", INT_n, 0);
    ack_now();

    // 6: overruns while granted, then reset in WAIT_ACK
    repeat (20) cycle();
    do_reset();
    pulse(5'b00010); cycle();
    chk("t6_granted", INT_n, 0);
    pulse(5'b00010); cycle();
    pulse(5'b00010); cycle();
    chk("t6_ovr", Ovr_Cnt, OVR_EXP);
    chk("t6_still_low", INT_n, 0);
    do_reset();
    chk("t6_rst_int", INT_n, 1);
    chk("t6_rst_ovr", Ovr_Cnt, 0);

    // randomized traffic
    begin
      bit noack;
      noack = 0;
      for (int c = 0; c < 3000; c++) begin
        if (c % 300 == 0) noack = ($urandom_range(0, 2) == 0);
        if (c == 1500) do_reset();
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 9) == 0) Rdy_In = Rdy_In ^ (N'(1) << i);
        if ($urandom_range(0, 19) == 0) Mask = ($urandom_range(0, 1) == 0) ? N'($urandom) : '1;
        En  = ($urandom_range(0, 59) != 0);
        Ack = !noack && ($urandom_range(0, 3) == 0);
        cycle();
      end
      Ack = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
